// File: rtl/lua_pkg.sv
// Shared definitions for the lua_3d linear address unit: FSM states,
// ordering encodings and the latency helper.
package lua_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL1  = 2'd1,
    MUL2  = 2'd2,
    FINAL = 2'd3
  } state_t;

  // ColMajor encodings
  localparam logic ORDER_ROW = 1'b0;  // X fastest
  localparam logic ORDER_COL = 1'b1;  // Z fastest

  // Accept edge to Done: two serial passes plus the reload and final cycles.
  function automatic int lua_latency(input int data_width);
    return 2 * data_width + 2;
  endfunction

  localparam int LUA_DATA_WIDTH = 16;
  localparam int LUA_LATENCY    = lua_latency(LUA_DATA_WIDTH);

endpackage

// File: rtl/lua_shift_mac.sv
// Serial unsigned multiply-accumulate: result = addend + mplier * mcand,
// one multiplier bit per cycle, MW cycles after load. Wraps modulo 2^AW.
// done is high during the final step; result is valid the cycle after.
module lua_shift_mac #(
  parameter int MW = 16,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [MW-1:0] mplier_in,
  input  logic [AW-1:0] mcand_in,
  input  logic [AW-1:0] addend_in,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] result
);

  localparam int CW = (MW > 1) ? $clog2(MW) : 1;
  localparam logic [CW-1:0] LAST = CW'(MW - 1);

  logic [AW-1:0] acc;
  logic [AW-1:0] mcand;
  logic [MW-1:0] mplier;
  logic [CW-1:0] cnt;

  assign done   = busy && (cnt == LAST);
  assign result = acc;

  // Shift-add datapath: load operands, then add the shifted multiplicand
  // whenever the current multiplier LSB is set.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, whatever the statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (load) begin
      acc    <= addend_in;
      mcand  <= mcand_in;
      mplier <= mplier_in;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/lua_3d.sv
// lua_3d: 3-D coordinate to flat address, Address = Base + linear index,
// row- or column-major, computed with one shared serial MAC in two passes.
// Optional feature macro: LUA_BOUNDS_CHECK_EN (out-of-range coordinates
// raise Error and force Address to 0).
module lua_3d
  import lua_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Start,
  input  logic [DATA_WIDTH-1:0] InputX,
  input  logic [DATA_WIDTH-1:0] InputY,
  input  logic [DATA_WIDTH-1:0] InputZ,
  input  logic [DATA_WIDTH-1:0] SizeX,
  input  logic [DATA_WIDTH-1:0] SizeY,
  input  logic [DATA_WIDTH-1:0] SizeZ,
  input  logic [ADDR_WIDTH-1:0] Base,
  input  logic                  ColMajor,
  output logic                  Ready,
  output logic                  Done,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic                  Error
);

  state_t state, state_next;

  logic                  accept;
  logic [DATA_WIDTH-1:0] outer, inner, size_inner;
  logic                  oob;

  logic [DATA_WIDTH-1:0] inner_q, size_inner_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic                  oob_q;

  logic                  mac_load, mac_busy, mac_done;
  logic [DATA_WIDTH-1:0] mac_mplier;
  logic [ADDR_WIDTH-1:0] mac_mcand, mac_addend, mac_result;

  assign accept = Start && (state == IDLE);

  // Axis selection by ordering and the optional bounds test on live inputs.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    outer      = InputZ;
    inner      = InputX;
    size_inner = SizeX;
    case (ColMajor)
      ORDER_ROW: begin
        outer      = InputZ;
        inner      = InputX;
        size_inner = SizeX;
      end
      ORDER_COL: begin
        outer      = InputX;
        inner      = InputZ;
        size_inner = SizeZ;
      end
      default: ;
    endcase
`ifdef LUA_BOUNDS_CHECK_EN
    oob = (InputX >= SizeX) || (InputY >= SizeY) || (InputZ >= SizeZ);
`else
    oob = 1'b0;
`endif
  end

  // Operands for the second pass and the final add, captured on accept.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      inner_q      <= '0;
      size_inner_q <= '0;
      base_q       <= '0;
      oob_q        <= 1'b0;
    end else if (accept) begin
      inner_q      <= inner;
      size_inner_q <= size_inner;
      base_q       <= Base;
      oob_q        <= oob;
    end
  end

  // MAC loading: pass 1 straight from the ports on accept (Outer*SizeY + Y),
  // pass 2 from the pass-1 result in the first MUL2 cycle (acc1*SizeInner + Inner).
  always_comb begin
    mac_load   = 1'b0;
    mac_mplier = SizeY;
    mac_mcand  = ADDR_WIDTH'(outer);
    mac_addend = ADDR_WIDTH'(InputY);
    if (accept) begin
      mac_load = 1'b1;
    end else if (state == MUL2 && !mac_busy) begin
      mac_load   = 1'b1;
      mac_mplier = size_inner_q;
      mac_mcand  = mac_result;
      mac_addend = ADDR_WIDTH'(inner_q);
    end
  end

  lua_shift_mac #(
    .MW(DATA_WIDTH),
    .AW(ADDR_WIDTH)
  ) u_mac (
    .clk      (Clk),
    .rst_n    (Rst_n),
    .load     (mac_load),
    .mplier_in(mac_mplier),
    .mcand_in (mac_mcand),
    .addend_in(mac_addend),
    .busy     (mac_busy),
    .done     (mac_done),
    .result   (mac_result)
  );

  // State register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic and the Ready output.
  always_comb begin
    state_next = state;
    Ready      = (state == IDLE);
    case (state)
      IDLE:    if (accept)   state_next = MUL1;
      MUL1:    if (mac_done) state_next = MUL2;
      MUL2:    if (mac_done) state_next = FINAL;
      FINAL:                 state_next = IDLE;
      default:               state_next = IDLE;
    endcase
  end

  // Result registers: Done pulses as the FSM leaves FINAL; Address and
  // Error hold until the next result.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Done    <= 1'b0;
      Address <= '0;
      Error   <= 1'b0;
    end else begin
      Done <= (state == FINAL);
      if (state == FINAL) begin
        Address <= oob_q ? '0 : (mac_result + base_q);
        Error   <= oob_q;
      end
    end
  end

endmodule

// File: tb/tb_lua_3d.sv
// Directed testbench for lua_3d: latency, orderings, base wrap, bounds,
// back-to-back throughput and asynchronous abort.
module tb_lua_3d;
  import lua_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        Start;
  logic [15:0] InputX, InputY, InputZ, SizeX, SizeY, SizeZ;
  logic [31:0] Base;
  logic        ColMajor;
  logic        Ready, Done, Error;
  logic [31:0] Address;

  int checks   = 0;
  int failures = 0;

  lua_3d #(.DATA_WIDTH(16), .ADDR_WIDTH(32)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start),
    .InputX(InputX), .InputY(InputY), .InputZ(InputZ),
    .SizeX(SizeX), .SizeY(SizeY), .SizeZ(SizeZ),
    .Base(Base), .ColMajor(ColMajor),
    .Ready(Ready), .Done(Done), .Address(Address), .Error(Error)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply a request, hold Start for the accept edge, scramble inputs while
  // busy, then count edges after the accept edge until Done is seen.
  task automatic run_op(input logic [15:0] x, y, z, sx, sy, sz,
                        input logic [31:0] base, input logic cm, output int cyc);
    @(negedge Clk);
    InputX = x; InputY = y; InputZ = z;
    SizeX = sx; SizeY = sy; SizeZ = sz;
    Base = base; ColMajor = cm; Start = 1'b1;
    check("ready_before_accept", Ready, 1'b1);
    @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0;
    InputX = 16'h1234; InputY = 16'h0777; InputZ = 16'h0abc;
    SizeX = 16'h0003; Base = 32'hdead_beef; ColMajor = ~cm;
    check("ready_low_busy", Ready, 1'b0);
    cyc = 0;
    while (!Done && cyc < 200) begin
      @(negedge Clk);
      cyc++;
    end
  endtask

  // Completion checks plus one-cycle Done and held Address.
  task automatic check_result(input string tag, input int cyc,
                              input logic [31:0] exp_addr, input logic exp_err);
    check({tag, "_latency"}, cyc, LUA_LATENCY);
    check({tag, "_addr"}, Address, exp_addr);
    check({tag, "_err"}, Error, exp_err);
    check({tag, "_ready_with_done"}, Ready, 1'b1);
    @(negedge Clk);
    check({tag, "_done_width"}, Done, 1'b0);
    check({tag, "_addr_hold"}, Address, exp_addr);
  endtask

  int  cyc;
  bit  seen;

  initial begin
    Rst_n = 1'b0; Start = 1'b0;
    InputX = '0; InputY = '0; InputZ = '0;
    SizeX = '0; SizeY = '0; SizeZ = '0; Base = '0; ColMajor = 1'b0;
    repeat (2) @(negedge Clk);
    check("rst_ready", Ready, 1'b1);
    check("rst_done", Done, 1'b0);
    check("rst_addr", Address, 32'd0);
    check("rst_err", Error, 1'b0);
    Rst_n = 1'b1;

    // Row-major basics
    run_op(16'd4, 16'd5, 16'd0, 16'd10, 16'd8, 16'd4, 32'd0, 1'b0, cyc);
    check_result("row_z0", cyc, 32'd54, 1'b0);
    run_op(16'd4, 16'd5, 16'd2, 16'd10, 16'd8, 16'd4, 32'd1000, 1'b0, cyc);
    check_result("row_base", cyc, 32'd1214, 1'b0);
    // Column-major: (4*8+5)*4+2
    run_op(16'd4, 16'd5, 16'd2, 16'd10, 16'd8, 16'd4, 32'd0, 1'b1, cyc);
    check_result("col", cyc, 32'd150, 1'b0);
    // Base wrap-around
    run_op(16'h20, 16'd0, 16'd0, 16'd64, 16'd8, 16'd4, 32'hFFFF_FFF0, 1'b0, cyc);
    check_result("wrap", cyc, 32'h0000_0010, 1'b0);
    // X out of range
    run_op(16'd10, 16'd5, 16'd0, 16'd10, 16'd8, 16'd4, 32'd0, 1'b0, cyc);
`ifdef LUA_BOUNDS_CHECK_EN
    check_result("oob", cyc, 32'd0, 1'b1);
`else
    check_result("oob", cyc, 32'd60, 1'b0);
`endif
    // Zero size: 0*... -> only the inner term survives: (0*0+0)*10+4
    run_op(16'd4, 16'd0, 16'd0, 16'd10, 16'd0, 16'd0, 32'd7, 1'b0, cyc);
`ifdef LUA_BOUNDS_CHECK_EN
    check_result("zero_size", cyc, 32'd0, 1'b1);
`else
    check_result("zero_size", cyc, 32'd11, 1'b0);
`endif

    // Back-to-back with Start held high: Z=0 then Z=1
    @(negedge Clk);
    InputX = 16'd4; InputY = 16'd5; InputZ = 16'd0;
    SizeX = 16'd10; SizeY = 16'd8; SizeZ = 16'd4; Base = 32'd0; ColMajor = 1'b0;
    Start = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    InputZ = 16'd1;  // change while busy; also the second request's Z
    cyc = 0;
    while (!Done && cyc < 200) begin
      @(negedge Clk);
      cyc++;
    end
    check("b2b_first_latency", cyc, LUA_LATENCY);
    check("b2b_first_addr", Address, 32'd54);
    cyc = 0;
    @(posedge Clk);  // second accept edge
    @(negedge Clk);
    cyc++;
    Start = 1'b0;
    InputX = 16'd9; SizeX = 16'd2;
    while (!Done && cyc < 200) begin
      @(negedge Clk);
      cyc++;
    end
    check("b2b_spacing", cyc, LUA_LATENCY + 1);
    check("b2b_second_addr", Address, 32'd134);

    // Asynchronous abort at cycle 10 of an operation
    @(negedge Clk);
    InputX = 16'd4; InputY = 16'd5; InputZ = 16'd0; SizeX = 16'd10;
    Start = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0;
    repeat (9) @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    check("abort_ready", Ready, 1'b1);
    check("abort_done", Done, 1'b0);
    check("abort_addr", Address, 32'd0);
    check("abort_err", Error, 1'b0);
    @(negedge Clk);
    Rst_n = 1'b1;
    seen = 1'b0;
    repeat (50) begin
      @(negedge Clk);
      if (Done) seen = 1'b1;
    end
    check("abort_no_done", seen, 1'b0);
    run_op(16'd4, 16'd5, 16'd2, 16'd10, 16'd8, 16'd4, 32'd1000, 1'b0, cyc);
    check_result("after_abort", cyc, 32'd1214, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
